// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding control.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned WAIT_CNT_W = 4;

  // Control bits common to every shadowed stage (EX, MEM, WB).
  typedef struct packed {
    logic v;
    logic reg_write;
  } stage_shadow_t;

  localparam stage_shadow_t SHADOW_NOP = '{v: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/mips_fwd_mux.sv
// EX-stage operand selection: register value, WB result or MEM ALU result.
module mips_fwd_mux
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        a_sel,
  input  logic [1:0]        b_sel,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] mem_val,
  input  logic [DATA_W-1:0] wb_val,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);

  function automatic logic [DATA_W-1:0] pick(input logic [1:0]        sel,
                                             input logic [DATA_W-1:0] reg_val,
                                             input logic [DATA_W-1:0] m_val,
                                             input logic [DATA_W-1:0] w_val);
    case (sel)
      FWD_MEM: pick = m_val;
      FWD_WB:  pick = w_val;
      default: pick = reg_val;
    endcase
  endfunction

  assign op_a = pick(a_sel, rd1, mem_val, wb_val);
  assign op_b = pick(b_sel, rd2, mem_val, wb_val);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: data stalls, EX forwarding,
// branch flush and multi-cycle data-memory freeze, tracked with stage shadows.
module mips_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              ex_branch_taken,
  input  logic [DATA_W-1:0] ex_rd1,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              freeze,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b
);

  typedef logic [REG_AW-1:0] reg_t;

  stage_shadow_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  reg_t ex_dest_q, ex_dest_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  reg_t mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
  logic ex_load_q, ex_load_d, ex_mem_acc_q, ex_mem_acc_d;
  logic mem_mem_acc_q, mem_mem_acc_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic waited_q, waited_d;

  logic hit_ex_c, hit_mem_c, hit_wb_c, stall_c, mem_start_c, freeze_c;

  function automatic logic hit(input stage_shadow_t s, input reg_t dest,
                               input reg_t src, input logic used);
    return used && s.v && s.reg_write && (dest == src) && (src != REG_AW'(REG_ZERO));
  endfunction

  // Hazard detection and output priority: freeze > branch > data stall.
  always_comb begin
    hit_ex_c  = hit(ex_q, ex_dest_q, id_rs, id_use_rs) || hit(ex_q, ex_dest_q, id_rt, id_use_rt);
    hit_mem_c = hit(mem_q, mem_dest_q, id_rs, id_use_rs) || hit(mem_q, mem_dest_q, id_rt, id_use_rt);
    hit_wb_c  = hit(wb_q, wb_dest_q, id_rs, id_use_rs) || hit(wb_q, wb_dest_q, id_rt, id_use_rt);
    stall_c   = id_valid && (FWD_EN ? (hit_ex_c && ex_load_q)
                                    : (hit_ex_c || hit_mem_c || hit_wb_c));
    // A held access that already finished its wait must not re-arm the counter.
    mem_start_c = (MEM_WAIT != 0) && mem_q.v && mem_mem_acc_q &&
                  (wait_cnt_q == '0) && !waited_q;
    freeze_c    = mem_start_c || (wait_cnt_q != '0);

    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = freeze_c;
    if (freeze_c) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (stall_c) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // Forwarding selects for the EX instruction; MEM wins over WB, loads never forward from MEM.
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (FWD_EN) begin
      if (hit(mem_q, mem_dest_q, ex_rs_q, 1'b1) && !mem_mem_acc_q) fwd_a_sel = FWD_MEM;
      else if (hit(wb_q, wb_dest_q, ex_rs_q, 1'b1))                 fwd_a_sel = FWD_WB;
      if (hit(mem_q, mem_dest_q, ex_rt_q, 1'b1) && !mem_mem_acc_q) fwd_b_sel = FWD_MEM;
      else if (hit(wb_q, wb_dest_q, ex_rt_q, 1'b1))                 fwd_b_sel = FWD_WB;
    end
  end

  // Shadow advance mirrors the pipeline registers under the controls driven above.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (mem_start_c)             wait_cnt_d = WAIT_CNT_W'(MEM_WAIT - 1);
    else if (wait_cnt_q != '0)   wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
    waited_d = freeze_c && (wait_cnt_d == '0);

    ex_d          = ex_q;
    ex_dest_d     = ex_dest_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_load_d     = ex_load_q;
    ex_mem_acc_d  = ex_mem_acc_q;
    mem_d         = mem_q;
    mem_dest_d    = mem_dest_q;
    mem_mem_acc_d = mem_mem_acc_q;
    wb_d          = SHADOW_NOP;
    wb_dest_d     = wb_dest_q;
    if (!freeze_c) begin
      wb_d          = mem_q;
      wb_dest_d     = mem_dest_q;
      mem_d         = ex_q;
      mem_dest_d    = ex_dest_q;
      mem_mem_acc_d = ex_mem_acc_q;
      ex_d.v        = id_valid && !bubble_ex;
      ex_d.reg_write = id_reg_write;
      ex_dest_d     = id_dest;
      // Unused sources are stored as r0 so they can never match.
      ex_rs_d       = id_use_rs ? id_rs : REG_AW'(REG_ZERO);
      ex_rt_d       = id_use_rt ? id_rt : REG_AW'(REG_ZERO);
      ex_load_d     = id_load;
      ex_mem_acc_d  = id_load || id_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= SHADOW_NOP;
      ex_dest_q     <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_load_q     <= 1'b0;
      ex_mem_acc_q  <= 1'b0;
      mem_q         <= SHADOW_NOP;
      mem_dest_q    <= '0;
      mem_mem_acc_q <= 1'b0;
      wb_q          <= SHADOW_NOP;
      wb_dest_q     <= '0;
      wait_cnt_q    <= '0;
      waited_q      <= 1'b0;
    end else begin
      ex_q          <= ex_d;
      ex_dest_q     <= ex_dest_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_load_q     <= ex_load_d;
      ex_mem_acc_q  <= ex_mem_acc_d;
      mem_q         <= mem_d;
      mem_dest_q    <= mem_dest_d;
      mem_mem_acc_q <= mem_mem_acc_d;
      wb_q          <= wb_d;
      wb_dest_q     <= wb_dest_d;
      wait_cnt_q    <= wait_cnt_d;
      waited_q      <= waited_d;
    end
  end

  mips_fwd_mux #(.DATA_W(DATA_W)) u_fwd_mux (
    .a_sel   (fwd_a_sel),
    .b_sel   (fwd_b_sel),
    .rd1     (ex_rd1),
    .rd2     (ex_rd2),
    .mem_val (mem_alu_result),
    .wb_val  (wb_result),
    .op_a    (ex_op_a),
    .op_b    (ex_op_b)
  );

endmodule
